// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01,
        DWAIT  = 2'b10
    } hz_state_t;

    // Wide enough for LOAD_LAT-2 with LOAD_LAT up to 7.
    localparam int LCNT_W = 3;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage operand forwarding; the EX/MEM result is younger and wins over MEM/WB.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              exmem_regwen,
    input  logic              memwb_regwen,
    output fwd_t              fwd_a,
    output fwd_t              fwd_b
);

    function automatic fwd_t fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] em_rd,
        input logic              em_wen,
        input logic [REG_AW-1:0] mw_rd,
        input logic              mw_wen
    );
        fwd_t sel;
        sel = FWD_NONE;
        if (em_wen && (em_rd != '0) && (em_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (mw_wen && (mw_rd != '0) && (mw_rd == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs, exmem_rd, exmem_regwen, memwb_rd, memwb_regwen);
        fwd_b = fwd_sel(ex_rt, exmem_rd, exmem_regwen, memwb_rd, memwb_regwen);
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: latch enables/flushes for load-use, data-memory wait and
// taken-branch hazards, EX forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_use_rs,
    input  logic              ifid_use_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_memren,
    input  logic              idex_regwen,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              exmem_regwen,
    input  logic              memwb_regwen,
    input  logic              exmem_memreq,
    input  logic              branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output fwd_t              fwd_a,
    output fwd_t              fwd_b,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    hz_state_t         state, nstate, eff;
    logic [LCNT_W-1:0] lcnt, nlcnt;
    logic              ret_ls, nret_ls;
    logic              lu, mm;
    logic              pc_r, ifid_r, idex_r, exmem_r, memwb_r;
    logic              ifid_fl_r, idex_fl_r, memwb_fl_r;
    fwd_t              fa_r, fb_r;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .exmem_rd     (exmem_rd),
        .memwb_rd     (memwb_rd),
        .exmem_regwen (exmem_regwen),
        .memwb_regwen (memwb_regwen),
        .fwd_a        (fa_r),
        .fwd_b        (fb_r)
    );

    assign lu = idex_memren && idex_regwen && (idex_rd != '0) &&
                ((ifid_use_rs && (ifid_rs == idex_rd)) ||
                 (ifid_use_rt && (ifid_rt == idex_rd)));
    assign mm = exmem_memreq && !dhit;

    // DWAIT only freezes the pipeline; once dhit arrives we continue as the frozen state would.
    assign eff = (state == DWAIT) ? (ret_ls ? LSTALL : RUN) : state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= RUN;
            lcnt   <= '0;
            ret_ls <= 1'b0;
        end else begin
            state  <= nstate;
            lcnt   <= nlcnt;
            ret_ls <= nret_ls;
        end
    end

    always_comb begin
        nstate  = eff;
        nlcnt   = lcnt;
        nret_ls = 1'b0;
        if (mm) begin
            nstate  = DWAIT;
            nret_ls = (eff == LSTALL);
        end else if (branch_taken) begin
            nstate = RUN;
            nlcnt  = '0;
        end else if (eff == LSTALL) begin
            if (lcnt == '0) begin
                nstate = RUN;
            end else begin
                nlcnt = lcnt - LCNT_W'(1);
            end
        end else if (lu && (LOAD_LAT > 1)) begin
            nstate = LSTALL;
            nlcnt  = LCNT_INIT;
        end
    end

    always_comb begin
        pc_r       = 1'b1;
        ifid_r     = 1'b1;
        idex_r     = 1'b1;
        exmem_r    = 1'b1;
        memwb_r    = 1'b1;
        ifid_fl_r  = 1'b0;
        idex_fl_r  = 1'b0;
        memwb_fl_r = 1'b0;
        if (mm) begin
            pc_r       = 1'b0;
            ifid_r     = 1'b0;
            idex_r     = 1'b0;
            exmem_r    = 1'b0;
            memwb_fl_r = 1'b1;
        end else if (branch_taken) begin
            ifid_fl_r = 1'b1;
            idex_fl_r = 1'b1;
        end else if ((eff == LSTALL) || lu) begin
            // Holding IF/ID here also covers a concurrent fetch miss: the dependent
            // instruction must not be replaced by a bubble.
            pc_r      = 1'b0;
            ifid_r    = 1'b0;
            idex_fl_r = 1'b1;
        end else if (!ihit) begin
            pc_r      = 1'b0;
            ifid_fl_r = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
        end else if (!pc_r && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Reset overrides every control output so the datapath latches stay frozen.
    assign pc_en       = nRST & pc_r;
    assign ifid_en     = nRST & ifid_r;
    assign idex_en     = nRST & idex_r;
    assign exmem_en    = nRST & exmem_r;
    assign memwb_en    = nRST & memwb_r;
    assign ifid_flush  = nRST & ifid_fl_r;
    assign idex_flush  = nRST & idex_fl_r;
    assign memwb_flush = nRST & memwb_fl_r;
    assign fwd_a       = nRST ? fa_r : FWD_NONE;
    assign fwd_b       = nRST ? fb_r : FWD_NONE;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized and directed bench for hazard_ctrl_unit against a bubble-count reference model.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 3;
    localparam int CNT_W    = 6;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              ihit, dhit;
    logic [REG_AW-1:0] ifid_rs, ifid_rt, idex_rd, ex_rs, ex_rt, exmem_rd, memwb_rd;
    logic              ifid_use_rs, ifid_use_rt, idex_memren, idex_regwen;
    logic              exmem_regwen, memwb_regwen, exmem_memreq, branch_taken;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_flush, idex_flush, memwb_flush;
    fwd_t              fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cycles;

    hazard_ctrl_unit #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
        .idex_rd(idex_rd), .idex_memren(idex_memren), .idex_regwen(idex_regwen),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_regwen(exmem_regwen), .memwb_regwen(memwb_regwen),
        .exmem_memreq(exmem_memreq), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    logic [7:0] got_ctl;
    assign got_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};

    int         n_chk = 0;
    int         n_err = 0;
    int         m_rem = 0;   // stall bubbles still owed after the current cycle
    int         m_cnt = 0;
    logic [7:0] obs_ctl;
    logic [1:0] obs_fa;
    int         cnt_a, cnt_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] src);
        if (exmem_regwen && exmem_rd != 0 && exmem_rd == src) return 2'b10;
        if (memwb_regwen && memwb_rd != 0 && memwb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_lu();
        return idex_memren && idex_regwen && idex_rd != 0 &&
               ((ifid_use_rs && ifid_rs == idex_rd) || (ifid_use_rt && ifid_rt == idex_rd));
    endfunction

    // {pc, ifid, idex, exmem, memwb enables, ifid/idex/memwb flushes}
    function automatic logic [7:0] model_ctl();
        if (exmem_memreq && !dhit) return 8'b00001_001;
        if (branch_taken)          return 8'b11111_110;
        if (m_rem > 0 || model_lu()) return 8'b00111_010;
        if (!ihit)                 return 8'b01111_100;
        return 8'b11111_000;
    endfunction

    task automatic model_update(input logic [7:0] e);
        if (exmem_memreq && !dhit) begin
        end else if (branch_taken) m_rem = 0;
        else if (m_rem > 0)        m_rem = m_rem - 1;
        else if (model_lu())       m_rem = LOAD_LAT - 1;
        if (!e[7] && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    endtask

    task automatic idle();
        ihit = 1; dhit = 1; ifid_rs = 0; ifid_rt = 0; ifid_use_rs = 0; ifid_use_rt = 0;
        idex_rd = 0; idex_memren = 0; idex_regwen = 0; ex_rs = 0; ex_rt = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_regwen = 0; memwb_regwen = 0;
        exmem_memreq = 0; branch_taken = 0;
    endtask

    task automatic step(input string tag);
        logic [7:0] e;
        @(negedge CLK);
        e = model_ctl();
        obs_ctl = got_ctl;
        obs_fa = fwd_a;
        chk({tag, ".ctl"}, 32'(got_ctl), 32'(e));
        chk({tag, ".fa"}, 32'(fwd_a), 32'(model_fwd(ex_rs)));
        chk({tag, ".fb"}, 32'(fwd_b), 32'(model_fwd(ex_rt)));
        chk({tag, ".cnt"}, 32'(stall_cycles), 32'(m_cnt));
        model_update(e);
        @(posedge CLK); #1;
    endtask

    task automatic set_load_use(input logic [REG_AW-1:0] rd);
        idex_rd = rd; idex_memren = 1; idex_regwen = 1; ifid_rs = 5; ifid_use_rs = 1;
    endtask

    initial begin
        idle();
        ex_rs = 3; exmem_rd = 3; exmem_regwen = 1;
        @(posedge CLK); #1;
        chk("rst.ctl", 32'(got_ctl), 32'h0);
        chk("rst.fa", 32'(fwd_a), 32'h0);
        chk("rst.cnt", 32'(stall_cycles), 32'h0);
        nRST = 1; m_rem = 0; m_cnt = 0;

        // Forwarding priority
        idle(); ex_rs = 3; exmem_rd = 3; memwb_rd = 3; exmem_regwen = 1; memwb_regwen = 1;
        step("fwd1"); chk("fwd.exmem", 32'(obs_fa), 32'h2);
        exmem_regwen = 0;
        step("fwd2"); chk("fwd.memwb", 32'(obs_fa), 32'h1);
        ex_rs = 0;
        step("fwd3"); chk("fwd.r0", 32'(obs_fa), 32'h0);

        // Load-use for LOAD_LAT cycles
        idle(); set_load_use(5);
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            step("lu");
            if (obs_ctl[7] == 0 && obs_ctl[1] == 1) cnt_a++;
            idle();
        end
        chk("lu.bubbles", 32'(cnt_a), 32'd3);
        chk("lu.stallcnt", 32'(stall_cycles), 32'd3);
        set_load_use(0);
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            step("lu0");
            if (obs_ctl[7] == 0) cnt_a++;
        end
        chk("lu0.bubbles", 32'(cnt_a), 32'd0);

        // Data-memory wait
        idle(); exmem_memreq = 1; dhit = 0;
        cnt_b = 0;
        for (int i = 0; i < 4; i++) begin
            step("dw");
            if (obs_ctl[4] == 0 && obs_ctl[0] == 1) cnt_b++;
        end
        chk("dw.cycles", 32'(cnt_b), 32'd4);
        dhit = 1;
        step("dwx"); chk("dw.exit", 32'(obs_ctl), 32'hF8);

        // Branch in second load-use stall cycle
        idle(); set_load_use(5);
        step("bl1");
        idle(); branch_taken = 1;
        step("bl2"); chk("bl.flush", 32'(obs_ctl), 32'b11111_110);
        idle();
        step("bl3"); chk("bl.run", 32'(obs_ctl), 32'hF8);

        // Memory miss and branch together
        idle(); exmem_memreq = 1; dhit = 0; branch_taken = 1;
        step("mb1"); chk("mb.wait", 32'(obs_ctl), 32'b00001_001);
        dhit = 1;
        step("mb2"); chk("mb.branch", 32'(obs_ctl), 32'b11111_110);

        // Reset in the middle of a data wait
        idle(); exmem_memreq = 1; dhit = 0; ex_rs = 3; exmem_rd = 3; exmem_regwen = 1;
        step("rw1");
        #2 nRST = 0;
        #1;
        chk("rw.ctl", 32'(got_ctl), 32'h0);
        chk("rw.fa", 32'(fwd_a), 32'h0);
        chk("rw.cnt", 32'(stall_cycles), 32'h0);
        @(posedge CLK); #1;
        nRST = 1; m_rem = 0; m_cnt = 0;
        idle();
        step("rw2"); chk("rw.run", 32'(obs_ctl), 32'hF8);

        // Randomized traffic; the narrow counter also reaches saturation here
        for (int i = 0; i < 1500; i++) begin
            ihit = ($urandom_range(0, 9) < 8);
            dhit = $urandom_range(0, 1);
            ifid_rs = REG_AW'($urandom_range(0, 3));
            ifid_rt = REG_AW'($urandom_range(0, 3));
            ifid_use_rs = $urandom_range(0, 1);
            ifid_use_rt = $urandom_range(0, 1);
            idex_rd = REG_AW'($urandom_range(0, 3));
            idex_memren = ($urandom_range(0, 9) < 4);
            idex_regwen = ($urandom_range(0, 9) < 7);
            ex_rs = REG_AW'($urandom_range(0, 3));
            ex_rt = REG_AW'($urandom_range(0, 3));
            exmem_rd = REG_AW'($urandom_range(0, 3));
            memwb_rd = REG_AW'($urandom_range(0, 3));
            exmem_regwen = ($urandom_range(0, 9) < 7);
            memwb_regwen = ($urandom_range(0, 9) < 7);
            exmem_memreq = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 9) < 1);
            step("rnd");
        end
        chk("sat.cnt", 32'(stall_cycles), 32'd63);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS datapath, and the successor to the single-rule load-use detector. It generates per-stage latch enables and flushes, and the EX-stage forwarding selects. It handles three sequential hazard types: multi-cycle load-use stalls, data-memory wait stalls, and taken-branch flushes. It also keeps a saturating stall-cycle performance counter. The block sits beside the pipeline registers and is driven by decoded stage fields plus ihit/dhit from the cache interface.

Parameters:
REG_AW, 5, register-address width; register 0 never hazards or forwards
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 32, width of the stall_cycles counter

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
ifid_rs, ifid_rt  in  REG_AW  source registers of the instruction in ID
ifid_use_rs, ifid_use_rt  in  1  ID instruction actually reads rs/rt
idex_rd  in  REG_AW  destination register of the instruction in EX
idex_memren, idex_regwen  in  1  EX instruction is a load / writes a register
ex_rs, ex_rt  in  REG_AW  source registers of the instruction in EX (forwarding)
exmem_rd, memwb_rd  in  REG_AW  destination registers in MEM / WB
exmem_regwen, memwb_regwen  in  1  write enables in MEM / WB
exmem_memreq  in  1  MEM-stage instruction issues dmemREN or dmemWEN
branch_taken  in  1  EX resolved a taken branch or jump
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage latch enables
ifid_flush, idex_flush, memwb_flush  out  1  load a bubble (all-zero control) into the latch
fwd_a, fwd_b  out  2  ALU operand selects (fwd_t)
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset: nRST low asynchronously forces state=RUN, lcnt=0, stall_cycles=0. While nRST is low, all *_en=0, all flushes=0, fwd=FWD_NONE.
- Forwarding (combinational):
  - fwd_a=FWD_EXMEM if exmem_regwen and exmem_rd!=0 and exmem_rd==ex_rs.
  - Else fwd_a=FWD_MEMWB if the same test passes on memwb_rd/memwb_regwen.
  - Else FWD_NONE. fwd_b is identical using ex_rt. EX/MEM wins when both match.
- Load-use hit (lu): idex_memren and idex_regwen and idex_rd!=0 and ((ifid_use_rs and ifid_rs==idex_rd) or (ifid_use_rt and ifid_rt==idex_rd)).
- Memory miss (mm): exmem_memreq and not dhit.
- FSM states:
  - RUN: default; all enables 1, flushes 0.
  - LSTALL: pc_en=0, ifid_en=0, idex_flush=1; lcnt decrements each cycle; exit to RUN on the cycle lcnt reaches 0.
  - DWAIT: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1; exit to RUN in the cycle dhit=1, and that exit cycle asserts all enables normally.
- Priority within a cycle, highest first: mm/DWAIT > branch_taken > lu/LSTALL > fetch miss.
- mm in RUN or LSTALL: DWAIT outputs apply in the same cycle and the next state is DWAIT. LSTALL progress is frozen: lcnt is held and resumes after DWAIT exits.
- branch_taken applies only when exmem_en=1. Effect: ifid_flush=1, idex_flush=1, pc_en=1 (target load). It cancels any lu or LSTALL: next state RUN, lcnt=0.
- lu in RUN, no mm, no branch:
  - LSTALL outputs apply in the same cycle.
  - If LOAD_LAT>1, load lcnt=LOAD_LAT-2 and go to LSTALL; otherwise stay in RUN.
  - Total bubbles inserted = LOAD_LAT.
- Fetch miss (not ihit) with nothing higher active: pc_en=0, ifid_flush=1, later stages advance. If lu is also active, ifid is held (ifid_en=0), not flushed.
- stall_cycles increments when pc_en=0 (outside reset) and saturates at all-ones.
- The block has no combinational path from any output back to an input.

Decomposition:
- Package hazard_pkg:
  - typedef enum logic [1:0] fwd_t {FWD_NONE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10}
  - typedef enum logic [1:0] hz_state_t {RUN, LSTALL, DWAIT}
- Sub-module fwd_unit: purely combinational forwarding select, instantiated once and parametrised by REG_AW.
- The top level holds the FSM, lcnt and stall_cycles.

Test Plan:
- Forward priority: exmem_rd=memwb_rd=ex_rs=3, both regwen=1 -> fwd_a=2'b10. Set exmem_regwen=0 -> fwd_a=2'b01. Set ex_rs=0 -> 2'b00.
- Load-use, LOAD_LAT=3: idex_rd=5 load, ifid_rs=5, use_rs=1 -> pc_en=0 and idex_flush=1 for exactly 3 cycles, then RUN; stall_cycles=3. Repeat with idex_rd=0 -> no stall.
- Memory wait: exmem_memreq=1, dhit low 4 cycles then high -> 4 cycles with exmem_en=0 and memwb_flush=1; the 5th cycle has all enables 1.
- Branch during LSTALL (LOAD_LAT=3, branch_taken in the 2nd stall cycle) -> ifid_flush=idex_flush=1 and pc_en=1 that cycle, RUN next; no further bubbles.
- Simultaneous mm and branch_taken -> DWAIT outputs only, no flush. Branch is honoured in the cycle dhit=1.
- Reset mid-DWAIT: assert nRST low asynchronously -> outputs drop immediately, stall_cycles=0; after release, state RUN with all enables 1.
